// File: rtl/cnt_ctrl_pkg.sv
// Shared state encoding and direction constants for the count controller.
package cnt_ctrl_pkg;

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Matches the downstream counter's U_D meaning.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/btn_cond.sv
// Push-button conditioner: 2-FF synchronizer, counting debouncer and rising-edge one-pulse.
module btn_cond #(
    parameter int unsigned DEB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic sys_rst,
    input  logic btn_raw,
    output logic pulse
);

    localparam int unsigned CW = $clog2(DEB_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dly1_q, dly2_q;
    logic          pulse_q;

    // Count disagreeing cycles; the level flips on the edge the count would reach DEB_CYC.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
            dly1_q  <= 1'b0;
            dly2_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            dly1_q  <= deb_q;
            dly2_q  <= dly1_q;
            pulse_q <= dly1_q & ~dly2_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/cnt_ctrl.sv
// Run/pause and direction controller producing count ticks and U_D for an up/down counter.
module cnt_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYC  = 1_000_000,
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic sys_rst,
    input  logic btn_dir,
    input  logic btn_run,
    output logic enable,
    output logic U_D,
    output logic running
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TERM = TW'(TICK_DIV - 1);

    logic          run_pulse, dir_pulse;
    state_e        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          en_q, en_d;
    logic          ud_q, ud_d;

    btn_cond #(.DEB_CYC(DEB_CYC)) u_btn_run (
        .clk     (clk),
        .sys_rst (sys_rst),
        .btn_raw (btn_run),
        .pulse   (run_pulse)
    );

    btn_cond #(.DEB_CYC(DEB_CYC)) u_btn_dir (
        .clk     (clk),
        .sys_rst (sys_rst),
        .btn_raw (btn_dir),
        .pulse   (dir_pulse)
    );

    // A run pulse at terminal count wins: pause, no tick, divider cleared.
    always_comb begin
        state_d = state_q;
        tick_d  = '0;
        en_d    = 1'b0;
        ud_d    = ud_q;
        if (dir_pulse) begin
            ud_d = (ud_q == DIR_UP) ? DIR_DOWN : DIR_UP;
        end
        unique case (state_q)
            PAUSE: begin
                if (run_pulse) state_d = RUN;
            end
            RUN: begin
                if (run_pulse) begin
                    state_d = PAUSE;
                end else begin
                    en_d   = (tick_q == TERM);
                    tick_d = (tick_q == TERM) ? '0 : tick_q + TW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= PAUSE;
            tick_q  <= '0;
            en_q    <= 1'b0;
            ud_q    <= DIR_UP;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            en_q    <= en_d;
            ud_q    <= ud_d;
        end
    end

    assign enable  = en_q;
    assign U_D     = ud_q;
    assign running = (state_q == RUN);

endmodule

// File: tb/tb_cnt_ctrl.sv
// Self-checking bench for cnt_ctrl: directed scenarios plus random buttons against a sample-window model.
module tb_cnt_ctrl;

    localparam int unsigned DEB  = 4;
    localparam int unsigned TDIV = 5;

    logic clk = 1'b0;
    logic sys_rst = 1'b1;
    logic btn_dir = 1'b0;
    logic btn_run = 1'b0;
    logic enable, U_D, running;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int s_start = 0;
    int hr = 0;
    int hd = 0;

    cnt_ctrl #(.DEB_CYC(DEB), .TICK_DIV(TDIV)) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .btn_dir (btn_dir),
        .btn_run (btn_run),
        .enable  (enable),
        .U_D     (U_D),
        .running (running)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: raw samples per edge; a level flips when the DEB samples taken 2..DEB+1 edges
    // ago all disagree with it; a rising flip acts on the FSM 3 edges later.
    bit q_run[$], q_dir[$], r_run[$], r_dir[$];
    bit deb_run, deb_dir, m_run, m_ud, m_en;
    int m_n, m_start;

    function automatic bit settle(input bit q[$], input bit lvl);
        for (int i = 0; i < int'(DEB); i++) if (q[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        q_run = {}; q_dir = {}; r_run = {}; r_dir = {};
        for (int i = 0; i < int'(DEB) + 2; i++) begin
            q_run.push_back(1'b0);
            q_dir.push_back(1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            r_run.push_back(1'b0);
            r_dir.push_back(1'b0);
        end
        deb_run = 0; deb_dir = 0; m_run = 0; m_ud = 0; m_en = 0; m_n = 0; m_start = 0;
    endtask

    task automatic model_step();
        bit rise_r, rise_d, rp, dp;
        q_run.push_back(btn_run); void'(q_run.pop_front());
        q_dir.push_back(btn_dir); void'(q_dir.pop_front());
        rise_r = 0;
        rise_d = 0;
        if (settle(q_run, deb_run)) begin deb_run = !deb_run; rise_r = deb_run; end
        if (settle(q_dir, deb_dir)) begin deb_dir = !deb_dir; rise_d = deb_dir; end
        r_run.push_back(rise_r); rp = r_run.pop_front();
        r_dir.push_back(rise_d); dp = r_dir.pop_front();
        m_ud ^= dp;
        if (m_run) begin
            if (rp) begin m_run = 0; m_en = 0; end
            else m_en = ((m_n - m_start) % int'(TDIV) == 0);
        end else begin
            m_en = 0;
            if (rp) begin m_run = 1; m_start = m_n; end
        end
        m_n++;
    endtask

    always @(posedge clk or posedge sys_rst) begin
        if (sys_rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        check("model_enable", enable, m_en);
        check("model_U_D", U_D, m_ud);
        check("model_running", running, m_run);
    end

    initial begin
        sys_rst = 1'b1;
        repeat (3) @(posedge clk);
        #3 sys_rst = 1'b0;
        tick();
        check("reset_enable", enable, 1'b0);
        check("reset_U_D", U_D, 1'b0);
        check("reset_running", running, 1'b0);
        repeat (4) tick();

        // Run start: running at e0+8, ticks at e0+13/18/23.
        btn_run = 1'b1;
        tick();
        repeat (7) tick();
        check("run_not_yet", running, 1'b0);
        tick();
        check("run_started", running, 1'b1);
        tick();
        btn_run = 1'b0;
        repeat (3) tick();
        check("tick1_before", enable, 1'b0);
        tick(); check("tick1", enable, 1'b1);
        tick(); check("tick1_width", enable, 1'b0);
        repeat (4) tick(); check("tick2", enable, 1'b1);
        tick(); check("tick2_width", enable, 1'b0);
        repeat (4) tick(); check("tick3", enable, 1'b1);
        tick(); check("tick3_width", enable, 1'b0);

        // Bounce rejection, then a clean press toggles U_D once.
        for (int k = 0; k < 4; k++) begin
            btn_dir = (k % 2 == 0);
            repeat (2) tick();
        end
        btn_dir = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("bounce_no_toggle", U_D, 1'b0);
        end
        btn_dir = 1'b1;
        tick();
        repeat (7) tick();
        check("dir_before", U_D, 1'b0);
        tick();
        check("dir_toggled", U_D, 1'b1);
        tick();
        btn_dir = 1'b0;
        repeat (15) tick();
        check("dir_once", U_D, 1'b1);

        // Asynchronous reset mid-cycle while running with U_D = 1.
        @(posedge clk);
        #3 sys_rst = 1'b1;
        #1;
        check("async_rst_enable", enable, 1'b0);
        check("async_rst_U_D", U_D, 1'b0);
        check("async_rst_running", running, 1'b0);
        tick();
        #2 sys_rst = 1'b0;
        tick();
        check("release_running", running, 1'b0);
        check("release_U_D", U_D, 1'b0);

        // Simultaneous presses from PAUSE.
        repeat (3) tick();
        btn_dir = 1'b1;
        btn_run = 1'b1;
        tick();
        repeat (7) tick();
        check("both_run_before", running, 1'b0);
        check("both_dir_before", U_D, 1'b0);
        tick();
        check("both_run_after", running, 1'b1);
        check("both_dir_after", U_D, 1'b1);
        s_start = cyc;
        tick();
        btn_dir = 1'b0;
        btn_run = 1'b0;
        repeat (12) tick();

        // Pause pulse aligned with terminal count.
        while (((cyc + 1 + 8 - s_start) % int'(TDIV)) != 0) tick();
        btn_run = 1'b1;
        tick();
        repeat (3) tick();
        check("pre_term_enable", enable, 1'b1);
        tick();
        check("pre_term_width", enable, 1'b0);
        repeat (3) tick();
        check("term_still_run", running, 1'b1);
        tick();
        check("term_paused", running, 1'b0);
        check("term_no_enable", enable, 1'b0);
        tick();
        btn_run = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("paused_no_enable", enable, 1'b0);
        end

        // Reset at debounce count 2 with run held; re-debounce from zero.
        btn_run = 1'b1;
        tick();
        repeat (3) tick();
        #1 sys_rst = 1'b1;
        tick();
        #2 sys_rst = 1'b0;
        tick();
        repeat (7) tick();
        check("rerun_not_yet", running, 1'b0);
        tick();
        check("rerun_started", running, 1'b1);
        repeat (20) tick();
        check("rerun_held_once", running, 1'b1);
        btn_run = 1'b0;
        repeat (15) tick();
        check("rerun_release", running, 1'b1);

        // Random buttons with short glitches and long holds, occasional reset.
        for (int i = 0; i < 2000; i++) begin
            if (hr == 0) begin
                btn_run = 1'($urandom_range(0, 1));
                hr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                  : int'($urandom_range(4, 14));
            end else hr--;
            if (hd == 0) begin
                btn_dir = 1'($urandom_range(0, 1));
                hd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                  : int'($urandom_range(4, 14));
            end else hd--;
            if ($urandom_range(0, 399) == 0) begin
                #2 sys_rst = 1'b1;
                tick();
                #2 sys_rst = 1'b0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cnt_ctrl.md
CNT_CTRL -- requirements
Module: cnt_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYC, default 1_000_000, meaning consecutive stable cycles required to accept a button level change (at least 2).
REQ-002 SHALL have parameter TICK_DIV, default 100_000_000, meaning clock cycles per count tick (at least 2).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port btn_dir  input  1  raw asynchronous direction push-button, active-high.
REQ-006 SHALL have port btn_run  input  1  raw asynchronous run/pause push-button, active-high.
REQ-007 SHALL have port enable  output  1  one-cycle count tick to the downstream up/down counter.
REQ-008 SHALL have port U_D  output  1  direction level to the downstream counter; 1 = down, 0 = up.
REQ-009 SHALL have port running  output  1  high while the FSM is in RUN.

Function
REQ-010 SHALL pass each raw button through a 2-FF synchronizer before any other use.
REQ-011 SHALL debounce each synchronized button as follows: a per-button counter counts cycles in which the synced level differs from the debounced level, and clears on any cycle where they agree.
REQ-012 SHALL flip the debounced level on the edge where that counter would reach DEB_CYC.
REQ-013 SHALL generate a press pulse, high for exactly 1 cycle, on each 0->1 transition of the debounced level; a 1->0 transition SHALL generate no pulse.
REQ-014 SHALL assert the press pulse exactly DEB_CYC+3 cycles after the first rising edge at which a clean raw level is sampled high.
REQ-015 SHALL produce no pulse for any raw glitch or bounce shorter than DEB_CYC cycles.
REQ-016 SHALL have FSM states PAUSE (reset state) and RUN: run pulse in PAUSE -> RUN; run pulse in RUN -> PAUSE; no other transitions.
REQ-017 SHALL toggle U_D on each dir pulse, registered, in either FSM state; U_D SHALL change on the edge after the pulse.
REQ-018 SHALL use a tick counter of width $clog2(TICK_DIV), counting 0..TICK_DIV-1 and wrapping to 0 only while in RUN; it SHALL be held at 0 in PAUSE.
REQ-019 SHALL assert enable, registered, for 1 cycle when the tick counter equals TICK_DIV-1 in RUN.
REQ-020 SHALL place the first enable exactly TICK_DIV cycles after the PAUSE->RUN transition, and subsequent enables every TICK_DIV cycles.
REQ-021 SHALL, when a run pulse coincides with the terminal count, perform the transition to PAUSE, keep enable low, and clear the counter.
REQ-022 SHALL, when dir and run pulses coincide, apply both actions in the same cycle.
REQ-023 SHALL NOT reset or stall the tick counter on a dir toggle while in RUN.
REQ-024 SHALL keep enable low at all times in PAUSE.
REQ-025 SHALL keep the button paths independent; a button held high indefinitely SHALL yield exactly one pulse.

Reset
REQ-026 SHALL, on sys_rst high, immediately clear all synchronizer FFs, debounce counters, debounced levels, pulses and the tick counter to 0.
REQ-027 SHALL, on sys_rst high, set FSM = PAUSE, enable = 0, U_D = 0 and running = 0.
REQ-028 SHALL, on reset asserted mid-press or mid-tick, discard all partial progress; after release, a still-held button SHALL be re-debounced from zero and produce one pulse.
REQ-029 SHALL release reset synchronously with respect to first activity; no output SHALL change on the release edge itself.

Structure
REQ-030 SHALL place the FSM state encoding (PAUSE = 1'b0, RUN = 1'b1) in shared package cnt_ctrl_pkg.
REQ-031 SHALL place the DIR_UP = 0 and DIR_DOWN = 1 constants in cnt_ctrl_pkg, matching the downstream counter's U_D meaning.
REQ-032 SHALL implement the synchronizer, debounce and one-pulse logic as sub-module btn_cond (params DEB_CYC; ports clk, sys_rst, btn_raw, pulse), instantiated twice.
REQ-033 SHALL keep the FSM, tick divider and U_D register in cnt_ctrl.

Verification (DEB_CYC=4, TICK_DIV=5)
REQ-034 SHALL check reset: sys_rst pulsed mid-simulation -> enable = 0, U_D = 0, running = 0 immediately, independent of clk.
REQ-035 SHALL check run start: btn_run held 10 cycles -> running rises 8 cycles after the first sampled-high edge; enable pulses at +5, +10 and +15 cycles thereafter, each 1 cycle wide.
REQ-036 SHALL check bounce rejection: btn_dir toggling 1,0,1,0 each 2 cycles, then low -> no U_D change; then held high 10 cycles -> U_D goes 0 -> 1 exactly once.
REQ-037 SHALL check pause at terminal count: run pulse aligned with tick counter = 4 -> no enable that cycle, running = 0, no enable for the next 20 cycles.
REQ-038 SHALL check simultaneous presses: btn_dir and btn_run rise on the same cycle from PAUSE, U_D = 0 -> in one cycle, running = 1 and U_D = 1.
REQ-039 SHALL check reset mid-press: sys_rst asserted at debounce count 2 while btn_run is held, then released -> exactly one run pulse, DEB_CYC+3 cycles after release.
